// File: rtl/bubble_spawner_if.sv
// bubble_spawner_if: bundle between the collision/level logic, the bubble
// motion bank and bubble_spawner.
//   master : the side that issues load/hit requests and reports slot state
//   slave  : bubble_spawner itself
interface bubble_spawner_if #(
    parameter int NUM_SLOTS = 8
);
    logic                      load;
    logic [10:0]               load_x;
    logic [10:0]               load_y;
    logic [2:0]                load_size;
    logic [NUM_SLOTS-1:0]      hit_req;
    logic [NUM_SLOTS*11-1:0]   bub_x;
    logic [NUM_SLOTS*11-1:0]   bub_y;
    logic [NUM_SLOTS*3-1:0]    bub_size;
    logic [NUM_SLOTS-1:0]      start;
    logic [10:0]               spawn_x;
    logic [10:0]               spawn_y;
    logic [2:0]                spawn_size;
    logic                      spawn_dir;
    logic [NUM_SLOTS-1:0]      kill;
    logic                      pop;
    logic [2:0]                pop_size;
    logic                      overflow;
    logic                      all_clear;

    modport master (
        output load, load_x, load_y, load_size, hit_req, bub_x, bub_y, bub_size,
        input  start, spawn_x, spawn_y, spawn_size, spawn_dir, kill, pop, pop_size,
               overflow, all_clear
    );

    modport slave (
        input  load, load_x, load_y, load_size, hit_req, bub_x, bub_y, bub_size,
        output start, spawn_x, spawn_y, spawn_size, spawn_dir, kill, pop, pop_size,
               overflow, all_clear
    );
endinterface

// File: rtl/bubble_spawner.sv
// bubble_spawner: bubble slot manager. Tracks which motion slots are live,
// spawns the level's first bubble on load and turns each hit on a live bubble
// into a kill plus two children one size smaller (left child moving left,
// right child moving right). All outputs are registered: every output value is
// computed together with the transition into the state that presents it.
//
// Optional feature macro: BUBBLE_SPAWN_CLAMP_EN
//   defined     -> right child x clamped to X_MAX - (OBJECT_SIZE << child size)
//   not defined -> right child x unclamped (motion block's wall bounce fixes it)
module bubble_spawner #(
    parameter int NUM_SLOTS   = 8,
    parameter int OBJECT_SIZE = 8,
    parameter int X_MAX       = 639
) (
    input logic             clk,
    input logic             reset,
    bubble_spawner_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_SLOTS);
    localparam logic [NUM_SLOTS-1:0] ONE = {{(NUM_SLOTS-1){1'b0}}, 1'b1};
`ifdef BUBBLE_SPAWN_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        KILL    = 3'd1,
        SPAWN_L = 3'd2,
        HOLD_L  = 3'd3,
        SPAWN_R = 3'd4,
        HOLD_R  = 3'd5,
        LOAD    = 3'd6,
        HOLD_LD = 3'd7
    } state_t;

    // Index of the lowest set bit (0 when none is set).
    function automatic logic [IDX_W-1:0] low_idx(input logic [NUM_SLOTS-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    state_t                 state_r, state_s;
    logic [NUM_SLOTS-1:0]   occupied_r, occupied_s;
    logic [NUM_SLOTS-1:0]   pending_r, pending_s;
    logic                   load_pend_r, load_pend_s;
    logic [10:0]            ld_x_r, ld_x_s, ld_y_r, ld_y_s;
    logic [2:0]             ld_size_r, ld_size_s;
    logic [IDX_W-1:0]       par_slot_r, par_slot_s;
    logic [10:0]            par_x_r, par_x_s, par_y_r, par_y_s;
    logic [2:0]             par_size_r, par_size_s;
    logic [NUM_SLOTS-1:0]   start_r, start_s, kill_r, kill_s;
    logic [10:0]            spawn_x_r, spawn_x_s, spawn_y_r, spawn_y_s;
    logic [2:0]             spawn_size_r, spawn_size_s, pop_size_r, pop_size_s;
    logic                   spawn_dir_r, spawn_dir_s, pop_r, pop_s;
    logic                   overflow_r, overflow_s, all_clear_r, all_clear_s;

    logic [NUM_SLOTS-1:0]   par_oh_s, occ_base_s, free_s, free_oh_s, pend_oh_s;
    logic [IDX_W-1:0]       pend_idx_s;
    logic [10:0]            pend_x_s, pend_y_s;
    logic [2:0]             pend_size_s, child_size_s;
    logic [10:0]            right_raw_s, right_lim_s, right_x_s;

    // Slot selection and child geometry; in KILL the parent slot already counts as free.
    always_comb begin
        par_oh_s             = '0;
        par_oh_s[par_slot_r] = 1'b1;
        if (state_r == KILL) begin
            occ_base_s = occupied_r & ~par_oh_s;
        end else begin
            occ_base_s = occupied_r;
        end
        free_s       = ~occ_base_s;
        free_oh_s    = free_s & (~free_s + ONE);
        pend_oh_s    = pending_r & (~pending_r + ONE);
        pend_idx_s   = low_idx(pending_r);
        pend_x_s     = bus.bub_x[int'(pend_idx_s) * 11 +: 11];
        pend_y_s     = bus.bub_y[int'(pend_idx_s) * 11 +: 11];
        pend_size_s  = bus.bub_size[int'(pend_idx_s) * 3 +: 3];
        child_size_s = par_size_r - 3'd1;
        right_raw_s  = par_x_r + (11'(OBJECT_SIZE) << child_size_s);
        right_lim_s  = 11'(X_MAX) - (11'(OBJECT_SIZE) << child_size_s);
        if (CLAMP_EN && (right_raw_s > right_lim_s)) begin
            right_x_s = right_lim_s;
        end else begin
            right_x_s = right_raw_s;
        end
    end

    // Next-state, next-output and bookkeeping for every register.
    always_comb begin
        state_s      = state_r;
        occupied_s   = occupied_r;
        pending_s    = pending_r | (bus.hit_req & occupied_r);
        load_pend_s  = load_pend_r | bus.load;
        ld_x_s       = bus.load ? bus.load_x : ld_x_r;
        ld_y_s       = bus.load ? bus.load_y : ld_y_r;
        ld_size_s    = bus.load ? bus.load_size : ld_size_r;
        par_slot_s   = par_slot_r;
        par_x_s      = par_x_r;
        par_y_s      = par_y_r;
        par_size_s   = par_size_r;
        start_s      = '0;
        kill_s       = '0;
        pop_s        = 1'b0;
        pop_size_s   = 3'd0;
        spawn_x_s    = spawn_x_r;
        spawn_y_s    = spawn_y_r;
        spawn_size_s = spawn_size_r;
        spawn_dir_s  = spawn_dir_r;
        overflow_s   = overflow_r;

        case (state_r)
            IDLE: begin
                if (load_pend_r) begin
                    // a load arriving this very cycle stays pending for next time
                    state_s      = LOAD;
                    load_pend_s  = bus.load;
                    spawn_x_s    = ld_x_r;
                    spawn_y_s    = ld_y_r;
                    spawn_size_s = ld_size_r;
                    spawn_dir_s  = 1'b1;
                    if (free_s != '0) begin
                        start_s    = free_oh_s;
                        occupied_s = occupied_r | free_oh_s;
                    end else begin
                        overflow_s = 1'b1;
                    end
                end else if (pending_r != '0) begin
                    state_s    = KILL;
                    par_slot_s = pend_idx_s;
                    par_x_s    = pend_x_s;
                    par_y_s    = pend_y_s;
                    par_size_s = pend_size_s;
                    kill_s     = pend_oh_s;
                    pop_s      = 1'b1;
                    pop_size_s = pend_size_s;
                end else begin
                    state_s = IDLE;
                end
            end
            KILL: begin
                occupied_s = occ_base_s;
                pending_s  = pending_s & ~par_oh_s;
                if (par_size_r == 3'd0) begin
                    state_s = IDLE;
                end else if (free_s != '0) begin
                    state_s      = SPAWN_L;
                    start_s      = free_oh_s;
                    occupied_s   = occ_base_s | free_oh_s;
                    spawn_x_s    = par_x_r;
                    spawn_y_s    = par_y_r;
                    spawn_size_s = child_size_s;
                    spawn_dir_s  = 1'b0;
                end else begin
                    // left child dropped; the right one has no slot either
                    state_s      = SPAWN_R;
                    overflow_s   = 1'b1;
                    spawn_x_s    = right_x_s;
                    spawn_y_s    = par_y_r;
                    spawn_size_s = child_size_s;
                    spawn_dir_s  = 1'b1;
                end
            end
            SPAWN_L: state_s = HOLD_L;
            HOLD_L: begin
                state_s      = SPAWN_R;
                spawn_x_s    = right_x_s;
                spawn_y_s    = par_y_r;
                spawn_size_s = child_size_s;
                spawn_dir_s  = 1'b1;
                if (free_s != '0) begin
                    start_s    = free_oh_s;
                    occupied_s = occupied_r | free_oh_s;
                end else begin
                    overflow_s = 1'b1;
                end
            end
            SPAWN_R: state_s = HOLD_R;
            HOLD_R:  state_s = IDLE;
            LOAD:    state_s = HOLD_LD;
            HOLD_LD: state_s = IDLE;
            default: state_s = IDLE;
        endcase

        all_clear_s = (occupied_s == '0) && (pending_s == '0) && !load_pend_s &&
                      (state_s == IDLE);
    end

    // State, bookkeeping and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            occupied_r   <= '0;
            pending_r    <= '0;
            load_pend_r  <= 1'b0;
            ld_x_r       <= 11'd0;
            ld_y_r       <= 11'd0;
            ld_size_r    <= 3'd0;
            par_slot_r   <= '0;
            par_x_r      <= 11'd0;
            par_y_r      <= 11'd0;
            par_size_r   <= 3'd0;
            start_r      <= '0;
            kill_r       <= '0;
            spawn_x_r    <= 11'd0;
            spawn_y_r    <= 11'd0;
            spawn_size_r <= 3'd0;
            spawn_dir_r  <= 1'b0;
            pop_r        <= 1'b0;
            pop_size_r   <= 3'd0;
            overflow_r   <= 1'b0;
            all_clear_r  <= 1'b1;
        end else begin
            state_r      <= state_s;
            occupied_r   <= occupied_s;
            pending_r    <= pending_s;
            load_pend_r  <= load_pend_s;
            ld_x_r       <= ld_x_s;
            ld_y_r       <= ld_y_s;
            ld_size_r    <= ld_size_s;
            par_slot_r   <= par_slot_s;
            par_x_r      <= par_x_s;
            par_y_r      <= par_y_s;
            par_size_r   <= par_size_s;
            start_r      <= start_s;
            kill_r       <= kill_s;
            spawn_x_r    <= spawn_x_s;
            spawn_y_r    <= spawn_y_s;
            spawn_size_r <= spawn_size_s;
            spawn_dir_r  <= spawn_dir_s;
            pop_r        <= pop_s;
            pop_size_r   <= pop_size_s;
            overflow_r   <= overflow_s;
            all_clear_r  <= all_clear_s;
        end
    end

    assign bus.start      = start_r;
    assign bus.kill       = kill_r;
    assign bus.spawn_x    = spawn_x_r;
    assign bus.spawn_y    = spawn_y_r;
    assign bus.spawn_size = spawn_size_r;
    assign bus.spawn_dir  = spawn_dir_r;
    assign bus.pop        = pop_r;
    assign bus.pop_size   = pop_size_r;
    assign bus.overflow   = overflow_r;
    assign bus.all_clear  = all_clear_r;
endmodule

// File: tb/tb_bubble_spawner.sv
// tb_bubble_spawner: scoreboard bench for bubble_spawner. Expected kill/start
// events are queued as stimulus is driven; a negedge monitor pops and compares
// them and also plays the motion bank (latching each started bubble's state).
module tb_bubble_spawner;
    localparam int NS = 8;
`ifdef BUBBLE_SPAWN_CLAMP_EN
    localparam logic [10:0] CLAMP_X = 11'd607;
`else
    localparam logic [10:0] CLAMP_X = 11'd632;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bubble_spawner_if #(.NUM_SLOTS(NS)) bif ();
    bubble_spawner #(.NUM_SLOTS(NS), .OBJECT_SIZE(8), .X_MAX(639)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    typedef struct {
        bit          is_kill;
        int          slot;
        logic [10:0] x;
        logic [10:0] y;
        logic [2:0]  sz;
        bit          dir;
    } ev_t;

    ev_t         q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [10:0] mx [NS] = '{default: 11'd0};
    logic [10:0] my [NS] = '{default: 11'd0};
    logic [2:0]  ms [NS] = '{default: 3'd0};
    bit          hold_pend = 1'b0;
    logic [10:0] hx, hy;
    logic [2:0]  hs;
    logic        hd;

    // Flatten the motion-bank model onto the bus.
    always_comb begin
        for (int i = 0; i < NS; i++) begin
            bif.bub_x[i*11 +: 11]  = mx[i];
            bif.bub_y[i*11 +: 11]  = my[i];
            bif.bub_size[i*3 +: 3] = ms[i];
        end
    end

    // Monitor: compare each kill/start against the queue, check spawn hold, model the bank.
    always @(negedge clk) begin
        if (reset) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                n_cmp++;
                if ({bif.spawn_x, bif.spawn_y, bif.spawn_size, bif.spawn_dir} !== {hx, hy, hs, hd}) begin
                    n_bad++;
                    $display("FAIL spawn_hold got x=%0d y=%0d size=%0d dir=%b want x=%0d y=%0d size=%0d dir=%b",
                             bif.spawn_x, bif.spawn_y, bif.spawn_size, bif.spawn_dir, hx, hy, hs, hd);
                end
                hold_pend = 1'b0;
            end
            if (bif.start != '0 || bif.kill != '0) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event got start=%b kill=%b want no event", bif.start, bif.kill);
                end else begin
                    ev_t         e;
                    logic [NS-1:0] oh;
                    e = q.pop_front();
                    oh = '0;
                    oh[e.slot] = 1'b1;
                    if (e.is_kill) begin
                        if (bif.kill !== oh || bif.start !== '0 || bif.pop !== 1'b1 || bif.pop_size !== e.sz) begin
                            n_bad++;
                            $display("FAIL kill_event got kill=%b start=%b pop=%b pop_size=%0d want kill=%b start=0 pop=1 pop_size=%0d",
                                     bif.kill, bif.start, bif.pop, bif.pop_size, oh, e.sz);
                        end
                    end else begin
                        if (bif.start !== oh || bif.kill !== '0 || bif.pop !== 1'b0 ||
                            bif.spawn_x !== e.x || bif.spawn_y !== e.y ||
                            bif.spawn_size !== e.sz || bif.spawn_dir !== e.dir) begin
                            n_bad++;
                            $display("FAIL start_event got start=%b kill=%b x=%0d y=%0d size=%0d dir=%b want start=%b x=%0d y=%0d size=%0d dir=%b",
                                     bif.start, bif.kill, bif.spawn_x, bif.spawn_y, bif.spawn_size, bif.spawn_dir,
                                     oh, e.x, e.y, e.sz, e.dir);
                        end
                    end
                end
                if (bif.start != '0) begin
                    for (int i = 0; i < NS; i++) begin
                        if (bif.start[i]) begin
                            mx[i] = bif.spawn_x;
                            my[i] = bif.spawn_y;
                            ms[i] = bif.spawn_size;
                        end
                    end
                    hold_pend = 1'b1;
                    {hx, hy, hs, hd} = {bif.spawn_x, bif.spawn_y, bif.spawn_size, bif.spawn_dir};
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push_start(input int slot, input int x, input int y, input int sz, input bit dir);
        q.push_back('{1'b0, slot, 11'(x), 11'(y), 3'(sz), dir});
    endtask

    task automatic push_kill(input int slot, input int sz);
        q.push_back('{1'b1, slot, 11'd0, 11'd0, 3'(sz), 1'b0});
    endtask

    task automatic pulse_load(input int x, input int y, input int sz, input int slot);
        push_start(slot, x, y, sz, 1'b1);
        bif.load      = 1'b1;
        bif.load_x    = 11'(x);
        bif.load_y    = 11'(y);
        bif.load_size = 3'(sz);
        tick(1);
        bif.load = 1'b0;
        tick(3);
    endtask

    task automatic pulse_hit(input logic [NS-1:0] mask);
        bif.hit_req = mask;
        tick(1);
        bif.hit_req = '0;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        for (int i = 0; i < budget && q.size() != 0; i++) tick(1);
        ok = (q.size() == 0);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        bif.load = 1'b0;
        bif.hit_req = '0;
        q.delete();
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_reset;
        tick(2);
        n_cmp++;
        if ({bif.start, bif.kill, bif.pop, bif.pop_size} !== '0) begin
            n_bad++;
            $display("FAIL reset_pulses got start=%b kill=%b pop=%b pop_size=%0d want 0",
                     bif.start, bif.kill, bif.pop, bif.pop_size);
        end
        n_cmp++;
        if ({bif.spawn_x, bif.spawn_y, bif.spawn_size, bif.spawn_dir} !== '0) begin
            n_bad++;
            $display("FAIL reset_spawn got x=%0d y=%0d size=%0d dir=%b want 0",
                     bif.spawn_x, bif.spawn_y, bif.spawn_size, bif.spawn_dir);
        end
        n_cmp++;
        if ({bif.overflow, bif.all_clear} !== 2'b01) begin
            n_bad++;
            $display("FAIL reset_flags got overflow=%b all_clear=%b want overflow=0 all_clear=1",
                     bif.overflow, bif.all_clear);
        end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_load;
        bit ok;
        do_reset();
        pulse_load(100, 50, 2, 0);
        wait_drain(20, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL load_drain got %0d pending want 0", q.size()); end
        n_cmp++;
        if (bif.all_clear !== 1'b0) begin
            n_bad++;
            $display("FAIL load_all_clear got=%b want=0", bif.all_clear);
        end
    endtask

    task automatic test_split;
        bit ok;
        do_reset();
        pulse_load(100, 200, 2, 0);
        push_kill(0, 2);
        push_start(0, 100, 200, 1, 1'b0);
        push_start(1, 116, 200, 1, 1'b1);
        pulse_hit(8'b0000_0001);
        wait_drain(30, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL split_drain got %0d pending want 0", q.size()); end
        tick(4);
        n_cmp++;
        if ({bif.overflow, bif.all_clear} !== 2'b00) begin
            n_bad++;
            $display("FAIL split_flags got overflow=%b all_clear=%b want 0 0", bif.overflow, bif.all_clear);
        end
    endtask

    task automatic test_size0;
        bit ok;
        do_reset();
        for (int i = 0; i < 4; i++) pulse_load(10 * i + 5, 40, 0, i);
        push_kill(0, 0);
        push_kill(1, 0);
        push_kill(2, 0);
        pulse_hit(8'b0000_0111);
        wait_drain(30, ok);
        push_kill(3, 0);
        bif.hit_req = 8'b0000_1000;
        tick(1);
        bif.hit_req = '0;
        tick(1);
        n_cmp++;
        if (bif.all_clear !== 1'b0) begin
            n_bad++;
            $display("FAIL size0_all_clear_kill got=%b want=0", bif.all_clear);
        end
        tick(1);
        n_cmp++;
        if (bif.all_clear !== 1'b1 || q.size() != 0) begin
            n_bad++;
            $display("FAIL size0_all_clear got=%b queue=%0d want all_clear=1 queue=0", bif.all_clear, q.size());
        end
        pulse_hit(8'hFF);
        tick(5);
        n_cmp++;
        if (bif.all_clear !== 1'b1) begin
            n_bad++;
            $display("FAIL ghost_hit_all_clear got=%b want=1", bif.all_clear);
        end
    endtask

    task automatic test_simultaneous;
        bit ok;
        do_reset();
        pulse_load(5, 5, 0, 0);
        pulse_load(50, 60, 1, 1);
        pulse_load(5, 5, 0, 2);
        pulse_load(300, 10, 0, 3);
        push_kill(1, 1);
        push_start(1, 50, 60, 0, 1'b0);
        push_start(4, 58, 60, 0, 1'b1);
        push_kill(3, 0);
        pulse_hit(8'b0000_1010);
        wait_drain(40, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL simul_drain got %0d pending want 0", q.size()); end
    endtask

    task automatic test_overflow;
        bit ok;
        do_reset();
        for (int i = 0; i < NS; i++) pulse_load(10 * i, 20, 1, i);
        wait_drain(20, ok);
        n_cmp++;
        if (bif.overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL full_no_overflow got=%b want=0", bif.overflow);
        end
        push_kill(5, 1);
        push_start(5, 50, 20, 0, 1'b0);
        pulse_hit(8'b0010_0000);
        wait_drain(30, ok);
        tick(4);
        n_cmp++;
        if (!ok || bif.overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL overflow_set got overflow=%b queue=%0d want overflow=1 queue=0", bif.overflow, q.size());
        end
        tick(10);
        n_cmp++;
        if (bif.overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL overflow_sticky got=%b want=1", bif.overflow);
        end
    endtask

    task automatic test_clamp;
        bit ok;
        do_reset();
        pulse_load(600, 100, 3, 0);
        push_kill(0, 3);
        push_start(0, 600, 100, 2, 1'b0);
        push_start(1, int'(CLAMP_X), 100, 2, 1'b1);
        pulse_hit(8'b0000_0001);
        wait_drain(30, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL clamp_drain got %0d pending want 0", q.size()); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        do_reset();
        pulse_load(200, 30, 2, 0);
        push_kill(0, 2);
        push_start(0, 200, 30, 1, 1'b0);
        pulse_hit(8'b0000_0001);
        wait_drain(20, ok);
        tick(1);
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({bif.start, bif.kill, bif.pop, bif.pop_size, bif.spawn_x, bif.spawn_y,
             bif.spawn_size, bif.spawn_dir} !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs got start=%b kill=%b pop=%b x=%0d y=%0d size=%0d dir=%b want 0",
                     bif.start, bif.kill, bif.pop, bif.spawn_x, bif.spawn_y, bif.spawn_size, bif.spawn_dir);
        end
        n_cmp++;
        if (!ok || {bif.overflow, bif.all_clear} !== 2'b01) begin
            n_bad++;
            $display("FAIL midreset_flags got overflow=%b all_clear=%b left_seen=%b want 0 1 1",
                     bif.overflow, bif.all_clear, ok);
        end
        tick(1);
        reset = 1'b0;
        tick(2);
        pulse_load(7, 8, 0, 0);
        wait_drain(20, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL midreset_reload got %0d pending want 0", q.size()); end
    endtask

    initial begin
        bif.load      = 1'b0;
        bif.load_x    = 11'd0;
        bif.load_y    = 11'd0;
        bif.load_size = 3'd0;
        bif.hit_req   = '0;
        test_reset();
        test_load();
        test_split();
        test_size0();
        test_simultaneous();
        test_overflow();
        test_clamp();
        test_reset_mid();
        tick(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
